// File: rtl/framebuf_ram.sv
// Single-clock frame buffer: sequential pixel capture driven by a start-of-frame
// strobe, with an independent registered random-access read port.
module framebuf_ram #(
  parameter int DW    = 8,
  parameter int AW    = 19,
  parameter int DEPTH = 307200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_sof,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] wr_ptr,
  output logic          frame_done,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } wr_state_t;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL_PTR   = AW'(DEPTH);
  localparam logic [AW:0]   DEPTH_WIDE = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [0:DEPTH-1];

  wr_state_t     state, state_next;
  logic [AW-1:0] ptr_next;
  logic [AW-1:0] wr_addr;
  logic          do_write;
  logic          overflow_next;
  logic          frame_done_next;
  logic          rd_in_range;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next      = state;
    ptr_next        = wr_ptr;
    overflow_next   = overflow;
    frame_done_next = 1'b0;
    do_write        = 1'b0;
    wr_addr         = wr_ptr;

    // A start-of-frame restarts capture from any state; a same-cycle pixel lands at 0.
    if (wr_sof) begin
      state_next    = CAPTURE;
      ptr_next      = '0;
      overflow_next = 1'b0;
      wr_addr       = '0;
    end

    if (wr_en) begin
      if (wr_sof || state == CAPTURE) begin
        do_write = 1'b1;
        if (wr_addr == LAST_ADDR) begin
          state_next      = DONE;
          ptr_next        = FULL_PTR;
          frame_done_next = 1'b1;
        end else begin
          ptr_next = wr_addr + 1'b1;
        end
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      wr_ptr     <= ptr_next;
      overflow   <= overflow_next;
      frame_done <= frame_done_next;
    end
  end

  // NOTE: the storage array is deliberately not reset so it maps onto block RAM; reset only gates the write.
  always_ff @(posedge clk) begin
    if (rst && do_write) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_WIDE;

  // Reading the array with the same edge as the write yields the old word (read-first).
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

endmodule
